// File: rtl/uart_tx_serializer.sv
// Buffered 8N1 UART transmitter: a small byte FIFO in front of a start/data/stop
// serializer that runs at CLK_FREQ/BAUD clocks per bit.
module uart_tx_serializer #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dout_vld,
   input  logic [7:0] dout_data,
   output logic       dout,
   output logic       busy,
   output logic       full,
   output logic       overflow
);

   localparam int B     = CLK_FREQ / BAUD;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CYC_W = (B > 1) ? $clog2(B) : 1;

   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(B - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               dout_q, dout_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [7:0]         mem_q [FIFO_DEPTH];

   logic full_w;
   logic pop;
   logic push;
   logic bit_end;

   // A pop frees a slot in the same cycle, so a write to a full FIFO is still taken.
   always_comb begin
      full_w   = (cnt_q == CNT_FULL);
      pop      = (state_q == IDLE) && (cnt_q != '0);
      push     = dout_vld && (!full_w || pop);
      ovf_d    = dout_vld && full_w && !pop;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      dout_d  = 1'b1;
      bit_end = (cyc_q == CYC_LAST);
      case (state_q)
         IDLE: begin
            cyc_d = '0;
            if (pop) begin
               shift_d = mem_q[rd_ptr_q];
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cyc_d   = '0;
               state_d = DATA;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cyc_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               cyc_d   = '0;
               state_d = IDLE;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cyc_d   = '0;
         end
      endcase

      // The line level is registered, so it is derived from the state being entered.
      case (state_d)
         START:   dout_d = 1'b0;
         DATA:    dout_d = shift_d[0];
         default: dout_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cyc_q    <= '0;
         bit_q    <= '0;
         dout_q   <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         bit_q    <= bit_d;
         dout_q   <= dout_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: the pointers and count decide what is valid.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      if (push) begin
         mem_q[wr_ptr_q] <= dout_data;
      end
   end

   assign dout     = dout_q;
   assign busy     = (state_q != IDLE) || (cnt_q != '0);
   assign full     = full_w;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: one instance at default baud, one at 16 clocks per bit for the long scenarios.
module tb_uart_tx_serializer;

   localparam int B_DFL  = 868;
   localparam int B_FST  = 16;
   localparam int FRAME  = 10 * B_FST + 1;
   localparam int PACE   = 221;

   logic       clk = 1'b0;
   logic       rst;
   logic       dfl_vld;
   logic       fst_vld;
   logic [7:0] data;
   logic       dfl_dout, dfl_busy, dfl_full, dfl_ovf;
   logic       fst_dout, fst_busy, fst_full, fst_ovf;

   int n_chk  = 0;
   int n_fail = 0;
   int now    = 0;

   always #5 clk = ~clk;

   uart_tx_serializer u_dfl (
      .clk       (clk),
      .rst       (rst),
      .dout_vld  (dfl_vld),
      .dout_data (data),
      .dout      (dfl_dout),
      .busy      (dfl_busy),
      .full      (dfl_full),
      .overflow  (dfl_ovf)
   );

   uart_tx_serializer #(
      .CLK_FREQ   (100_000_000),
      .BAUD       (6_250_000),
      .FIFO_DEPTH (4)
   ) u_fst (
      .clk       (clk),
      .rst       (rst),
      .dout_vld  (fst_vld),
      .dout_data (data),
      .dout      (fst_dout),
      .busy      (fst_busy),
      .full      (fst_full),
      .overflow  (fst_ovf)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step_to(input int target);
      while (now < target) begin
         @(posedge clk);
         #1;
         now++;
      end
   endtask

   task automatic reset_one();
      rst = 1'b1;
      step_to(now + 1);
      rst = 1'b0;
      now = 0;
   endtask

   task automatic chk_frame(input bit fast, input logic [7:0] byt, input int s);
      int b;
      b = fast ? B_FST : B_DFL;
      for (int i = 0; i < 10; i++) begin
         logic e;
         int   first;
         int   last;
         if (i == 0)      e = 1'b0;
         else if (i == 9) e = 1'b1;
         else             e = byt[3'(i - 1)];
         first = s + i * b;
         last  = first + b - 1;
         if (first >= now) begin
            step_to(first);
            chk($sformatf("frame_%02h_bit%0d_first", byt, i), fast ? fst_dout : dfl_dout, e);
         end
         step_to(last);
         chk($sformatf("frame_%02h_bit%0d_last", byt, i), fast ? fst_dout : dfl_dout, e);
         chk($sformatf("frame_%02h_bit%0d_busy", byt, i), fast ? fst_busy : dfl_busy, 1'b1);
      end
   endtask

   initial begin
      string msg;
      logic [7:0] pb;
      int s;

      // Reset with strobes held high: they must be ignored.
      rst     = 1'b1;
      dfl_vld = 1'b1;
      fst_vld = 1'b1;
      data    = 8'hFF;
      step_to(2);
      rst     = 1'b0;
      dfl_vld = 1'b0;
      fst_vld = 1'b0;
      now     = 0;
      for (int c = 0; c < 100; c++) begin
         step_to(c);
         chk("rst_dout", dfl_dout, 1'b1);
         chk("rst_busy", dfl_busy, 1'b0);
         chk("rst_full", dfl_full, 1'b0);
         chk("rst_ovf",  dfl_ovf,  1'b0);
      end
      chk("rst_fst_busy", fst_busy, 1'b0);

      // Single byte 't' at the default baud rate.
      now     = 0;
      dfl_vld = 1'b1;
      data    = 8'h74;
      chk("t_busy_c0", dfl_busy, 1'b0);
      step_to(1);
      dfl_vld = 1'b0;
      chk("t_dout_c1", dfl_dout, 1'b1);
      chk("t_busy_c1", dfl_busy, 1'b1);
      chk_frame(1'b0, 8'h74, 2);
      step_to(8682);
      chk("t_busy_end", dfl_busy, 1'b0);
      chk("t_dout_end", dfl_dout, 1'b1);

      // Burst of six writes: the sixth hits a full FIFO and is dropped.
      reset_one();
      for (int c = 0; c < 6; c++) begin
         step_to(c);
         fst_vld = 1'b1;
         data    = 8'(8'h31 + c);
         chk($sformatf("burst_full_c%0d", c), fst_full, c >= 5);
         chk($sformatf("burst_ovf_c%0d", c), fst_ovf, 1'b0);
      end
      step_to(6);
      fst_vld = 1'b0;
      chk("burst_ovf_c6", fst_ovf, 1'b1);
      chk("burst_full_c6", fst_full, 1'b1);
      step_to(7);
      chk("burst_ovf_c7", fst_ovf, 1'b0);
      for (int k = 0; k < 5; k++) begin
         s = 2 + k * FRAME;
         if (s - 1 >= now) begin
            step_to(s - 1);
            chk($sformatf("burst_idle_%0d", k), fst_dout, 1'b1);
         end
         chk_frame(1'b1, 8'(8'h31 + k), s);
      end
      step_to(2 + 5 * FRAME - 1);
      chk("burst_busy_end", fst_busy, 1'b0);
      chk("burst_full_end", fst_full, 1'b0);
      step_to(now + 3 * B_FST);
      chk("burst_no_sixth", fst_dout, 1'b1);

      // Full FIFO with a write landing on the IDLE pop cycle.
      reset_one();
      fst_vld = 1'b1;
      data    = 8'h41;
      step_to(1);
      fst_vld = 1'b0;
      for (int c = 2; c < 6; c++) begin
         step_to(c);
         fst_vld = 1'b1;
         data    = 8'(8'h40 + c);
      end
      step_to(6);
      fst_vld = 1'b0;
      chk("fp_full_c6", fst_full, 1'b1);
      chk("fp_busy_c6", fst_busy, 1'b1);
      chk_frame(1'b1, 8'h41, 2);
      step_to(2 + 10 * B_FST);
      chk("fp_full_pop", fst_full, 1'b1);
      fst_vld = 1'b1;
      data    = 8'h46;
      step_to(now + 1);
      fst_vld = 1'b0;
      chk("fp_ovf_after", fst_ovf, 1'b0);
      chk("fp_full_after", fst_full, 1'b1);
      for (int k = 1; k < 6; k++) begin
         s = 2 + k * FRAME;
         if (s - 1 >= now) begin
            step_to(s - 1);
            chk($sformatf("fp_idle_%0d", k), fst_dout, 1'b1);
         end
         chk_frame(1'b1, 8'(8'h41 + k), s);
      end
      step_to(2 + 6 * FRAME - 1);
      chk("fp_busy_end", fst_busy, 1'b0);

      // Paced upstream: 19 bytes, each frame finishes before the next write.
      reset_one();
      msg = "Hello UART world!";
      for (int i = 0; i < 19; i++) begin
         if (i < 17)       pb = msg[i];
         else if (i == 17) pb = 8'h0A;
         else              pb = 8'h0D;
         step_to(i * PACE);
         fst_vld = 1'b1;
         data    = pb;
         chk($sformatf("pace_full_w%0d", i), fst_full, 1'b0);
         step_to(i * PACE + 1);
         fst_vld = 1'b0;
         chk($sformatf("pace_full_q%0d", i), fst_full, 1'b0);
         chk($sformatf("pace_busy_q%0d", i), fst_busy, 1'b1);
         chk_frame(1'b1, pb, i * PACE + 2);
         step_to(i * PACE + 2 + 10 * B_FST);
         chk($sformatf("pace_idle_%0d", i), fst_busy, 1'b0);
      end

      // Reset in the middle of a 0x00 frame with two bytes queued behind it.
      reset_one();
      fst_vld = 1'b1;
      data    = 8'h00;
      step_to(1);
      data    = 8'h55;
      step_to(2);
      data    = 8'hAA;
      step_to(3);
      fst_vld = 1'b0;
      chk("mr_busy_c3", fst_busy, 1'b1);
      chk("mr_full_c3", fst_full, 1'b0);
      step_to(55);
      chk("mr_dout_pre", fst_dout, 1'b0);
      chk("mr_busy_pre", fst_busy, 1'b1);
      rst = 1'b1;
      step_to(56);
      rst = 1'b0;
      chk("mr_dout_post", fst_dout, 1'b1);
      chk("mr_busy_post", fst_busy, 1'b0);
      chk("mr_full_post", fst_full, 1'b0);
      chk("mr_ovf_post",  fst_ovf,  1'b0);
      for (int c = 57; c < 57 + 3 * FRAME; c++) begin
         step_to(c);
         chk("mr_quiet_dout", fst_dout, 1'b1);
         chk("mr_quiet_busy", fst_busy, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Buffered 8N1 UART transmitter that sits directly downstream of the message-printing stage. It accepts one-cycle `dout_vld`/`dout_data` byte strobes into a small FIFO and serializes each byte onto `dout` at a fixed baud rate: start bit, 8 data bits LSB first, one stop bit. The FIFO absorbs bursts so upstream pacing need not match frame length exactly. Overflow is reported, not back-pressured.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s. Bit period `B = CLK_FREQ / BAUD` uses integer division, giving 868 at the defaults.
- `FIFO_DEPTH`, default 4: byte capacity. Must be a power of two and at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dout_vld`  in  1  byte strobe. Every cycle it is high writes one byte.
- `dout_data`  in  8  byte sampled when `dout_vld` = 1.
- `dout`  out  1  serial line, registered; idle high.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `full`  out  1  high when the FIFO count equals `FIFO_DEPTH`.
- `overflow`  out  1  one-cycle pulse reporting a dropped write.

## Operation
- FIFO holds up to `FIFO_DEPTH` bytes using wrapping read/write pointers and a count of `log2(FIFO_DEPTH)+1` bits. Bytes leave in write order.
- Write while not full: byte stored, count incremented.
- Write while full with no pop in the same cycle: byte dropped, count unchanged, `overflow` = 1 in the next cycle only.
- Write and pop in the same cycle: both happen and count is unchanged. This holds even when the FIFO is full, in which case the write is accepted.
- Byte values are not filtered; 0x00 is transmitted like any other byte.
- FSM states are IDLE, START, DATA and STOP.
- IDLE: `dout` = 1. If the FIFO is non-empty, the head is popped into an 8-bit shift register, the bit counter is cleared, and the state moves to START.
- START: `dout` = 0 for B cycles, then the state moves to DATA.
- DATA: `dout` = shift[0]. Every B cycles the register shifts right and the bit index increments. After 8 bits the state moves to STOP.
- STOP: `dout` = 1 for B cycles, then the state moves to IDLE unconditionally.
- A single cycle counter `0..B-1` times each bit. It wraps to 0 at B-1 and is held at 0 in IDLE.
- `busy` = (state ≠ IDLE) | (count ≠ 0). `full` = (count == FIFO_DEPTH). Both are combinational from registers.

## Timing
- Reset values: `dout` = 1, `busy` = 0, `full` = 0, `overflow` = 0. Also state = IDLE, FIFO empty, pointers, count and counters 0.
- Cycle numbering for a single byte into an idle block: `dout_vld` is high in cycle 0.
- The byte is in the FIFO from cycle 1. The IDLE pop takes effect at the end of cycle 1.
- The start bit occupies cycles 2 .. B+1.
- Data bit k occupies cycles 2+(k+1)B .. 1+(k+2)B.
- The stop bit ends at cycle 1+10B, and `busy` = 0 from cycle 2+10B.
- Back-to-back frames: each STOP is followed by exactly one IDLE cycle with `dout` = 1. The frame-to-frame period is therefore 10B+1 cycles.
- Reset mid-frame: in the cycle after `rst` is sampled high, all outputs hold their reset values. The frame is truncated and queued bytes are discarded.
- `dout_vld` during reset is ignored.

## Test plan
Use defaults (B = 868).
- Reset behaviour: assert `rst` for 2 cycles, then stay idle 100 cycles -> `dout` = 1, `busy` = 0, `full` = 0, `overflow` = 0 throughout.
- Single byte 0x74 (`t`) written at cycle 0:
  - `dout` low over cycles 2..869.
  - Data bits 0,0,1,0,1,1,1,0 follow, each lasting 868 cycles.
  - Stop bit high ends at cycle 8681; `busy` falls at cycle 8682.
- Burst of 6 writes (0x31..0x36) on consecutive cycles 0..5:
  - `full` = 1 from cycle 5.
  - The 0x36 write is dropped and `overflow` pulses in cycle 6 only.
  - The line carries 0x31..0x35 in order, with frame starts 8681 cycles apart.
- Full plus simultaneous pop: fill to 4 entries, then write exactly on the cycle IDLE pops -> write accepted, no `overflow`, all 5 bytes transmitted.
- Upstream pacing: 19 bytes, one every 12000 cycles, ending with 0x0A, 0x0D -> all 19 received intact, `full` never asserted.
- Reset mid-frame: `rst` high at cycle 3000 of frame 0x00 with 2 bytes queued -> `dout` = 1 and `busy` = 0 next cycle; no further frames are emitted.
